mips_multicycle_datapath: RTL

Multicycle MIPS datapath driven by `main_controller` and the ALU decoder: PC, instruction and data registers, 32x32 register file, A/B/ALUOut holding registers, ALU and all steering muxes. It consumes the per-state control word the controller emits, returns `opcode`/`funct` to the control unit, and drives a single unified external memory port. One instruction completes over 3–5 controller states. All state updates occur on the rising edge of `clock`.

---
 rtl/mips_multicycle_datapath_if.sv | 27 ++
 rtl/mips_multicycle_datapath.sv | 113 +++++++++++
 2 files changed

// File: rtl/mips_multicycle_datapath_if.sv
// Control word, status and unified memory port between the multicycle MIPS
// datapath (slave) and its controller/memory side (master).
interface mips_multicycle_datapath_if;
   logic        MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite;
   logic        PCWrite, BranchEQ, BranchNE, RegWrite;
   logic [1:0]  PCSrc, ALUSrcB;
   logic [2:0]  ALUControl;
   logic [31:0] mem_rdata;
   logic [5:0]  opcode, funct;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_we, zero;
   logic [31:0] pc;

   modport master (
      output MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite,
             PCWrite, BranchEQ, BranchNE, RegWrite, PCSrc, ALUSrcB,
             ALUControl, mem_rdata,
      input  opcode, funct, mem_addr, mem_wdata, mem_we, zero, pc
   );

   modport slave (
      input  MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite,
             PCWrite, BranchEQ, BranchNE, RegWrite, PCSrc, ALUSrcB,
             ALUControl, mem_rdata,
      output opcode, funct, mem_addr, mem_wdata, mem_we, zero, pc
   );
endinterface

// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS datapath: PC/IR/Data/A/B/ALUOut registers, 32x32 register
// file, ALU and steering muxes, driven by an external per-state control word.
module mips_multicycle_datapath #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                        clock,
   input  logic                        reset,
   mips_multicycle_datapath_if.slave   bus
);

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [31:0] r_pc, r_ir, r_data, r_a, r_b, r_aluout;
   logic [31:0] r_rf [32];

   logic [4:0]  w_rs, w_rt, w_rd, w_wa;
   logic [31:0] w_rd1, w_rd2, w_wd, w_simm;
   logic [31:0] w_srca, w_srcb, w_alu, w_pcnext;
   logic        w_we, w_zero, w_pc_en;

   assign w_rs   = r_ir[25:21];
   assign w_rt   = r_ir[20:16];
   assign w_rd   = r_ir[15:11];
   assign w_simm = {{16{r_ir[15]}}, r_ir[15:0]};

   // $0 is forced to zero on read, so element 0 never matters
   assign w_rd1 = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
   assign w_rd2 = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

   assign w_wa = bus.RegDst   ? w_rd   : w_rt;
   assign w_wd = bus.MemtoReg ? r_data : r_aluout;
   assign w_we = bus.RegWrite && (w_wa != 5'd0);

   assign w_srca = bus.ALUSrcA ? r_a : r_pc;

   always_comb begin
      w_srcb = r_b;
      case (bus.ALUSrcB)
         2'b00:   w_srcb = r_b;
         2'b01:   w_srcb = 32'd4;
         2'b10:   w_srcb = w_simm;
         default: w_srcb = {w_simm[29:0], 2'b00};
      endcase
   end

   always_comb begin
      w_alu = 32'd0;
      case (bus.ALUControl)
         ALU_ADD: w_alu = w_srca + w_srcb;
         ALU_SUB: w_alu = w_srca - w_srcb;
         ALU_AND: w_alu = w_srca & w_srcb;
         ALU_OR:  w_alu = w_srca | w_srcb;
         ALU_SLT: w_alu = ($signed(w_srca) < $signed(w_srcb)) ? 32'd1 : 32'd0;
         default: w_alu = 32'd0;
      endcase
   end

   assign w_zero = (w_alu == 32'd0);

   // PCSrc=11 selects the current PC so an enabled load leaves it unchanged
   always_comb begin
      w_pcnext = r_pc;
      case (bus.PCSrc)
         2'b00:   w_pcnext = w_alu;
         2'b01:   w_pcnext = r_aluout;
         2'b10:   w_pcnext = {r_pc[31:28], r_ir[25:0], 2'b00};
         default: w_pcnext = r_pc;
      endcase
   end

   assign w_pc_en = bus.PCWrite | (bus.BranchEQ & w_zero) | (bus.BranchNE & ~w_zero);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc     <= RESET_PC;
         r_ir     <= '0;
         r_data   <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_aluout <= '0;
      end else begin
         if (w_pc_en)     r_pc <= w_pcnext;
         if (bus.IRWrite) r_ir <= bus.mem_rdata;
         r_data   <= bus.mem_rdata;
         r_a      <= w_rd1;
         r_b      <= w_rd2;
         r_aluout <= w_alu;
      end
   end

   // A/B sample the pre-write value on a same-edge write (no write-through)
   for (genvar g = 0; g < 32; g++) begin : g_rf
      always_ff @(posedge clock) begin
         if (reset)
            r_rf[g] <= '0;
         else if (w_we && (w_wa == 5'(g)))
            r_rf[g] <= w_wd;
      end
   end

   assign bus.opcode    = r_ir[31:26];
   assign bus.funct     = r_ir[5:0];
   assign bus.mem_addr  = bus.IorD ? r_aluout : r_pc;
   assign bus.mem_wdata = r_b;
   assign bus.mem_we    = bus.MemWrite;
   assign bus.zero      = w_zero;
   assign bus.pc        = r_pc;

endmodule
